// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, byte enables, FSM states and store-side helpers.
package riscv_mem_pkg;

   localparam int unsigned XLEN = 32;

   // funct3[1:0] access size; funct3[2] selects zero-extension on loads
   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } mem_state_e;

   // Half accesses need addr[0]==0, word accesses need addr[1:0]==0
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SIZE_B:  return 1'b0;
         SIZE_H:  return lane[0];
         default: return (lane != 2'b00);
      endcase
   endfunction

   // Store byte enables shifted into the addressed lane
   function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SIZE_B:  return 4'(BE_BYTE << lane);
         SIZE_H:  return 4'(BE_HALF << lane);
         default: return BE_WORD;
      endcase
   endfunction

   // Store data replicated across every lane so the byte enables alone pick the target
   function automatic logic [XLEN-1:0] store_wdata(input logic [1:0] size, input logic [XLEN-1:0] d);
      case (size)
         SIZE_B:  return {4{d[7:0]}};
         SIZE_H:  return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/load_data_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it to 32 bits.
module load_data_align
   import riscv_mem_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      lane,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] load_data_c
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selection followed by size-dependent extension
   always_comb begin
      byte_sel = 8'(rdata >> {lane, 3'b000});
      half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
      case (funct3[1:0])
         SIZE_B:  load_data_c = funct3[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         SIZE_H:  load_data_c = funct3[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: load_data_c = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the req/gnt/rvalid data-memory handshake, stalls upstream while an
// access is in flight and registers results toward MEM/WB.
module mem_access_stage
   import riscv_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] rs2_data_in,
   input  logic [4:0]  rd_in,
   input  logic [2:0]  funct3_in,
   input  logic        reg_write_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        stall_out,
   output logic [31:0] wb_data_out,
   output logic [4:0]  rd_out,
   output logic        reg_write_out,
   output logic        misalign_err_out,
   output logic        bus_err_out
);

   localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   mem_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic        req_d, we_d, rw_d, mis_d, berr_d;
   logic [31:0] addr_d, wdata_d, wb_d;
   logic [3:0]  be_d;
   logic [4:0]  rd_d;

   logic        mem_op;
   logic        misaligned;
   logic        timeout;
   logic [31:0] load_data;

   assign mem_op     = mem_read_in | mem_write_in;
   assign misaligned = is_misaligned(funct3_in[1:0], alu_result_in[1:0]);
   assign timeout    = (cnt_q == CNT_LAST);

   // Upstream holds its inputs while stalled, so the live lane/funct3 still describe the access
   load_data_align u_align (
      .rdata       (dmem_rdata),
      .lane        (alu_result_in[1:0]),
      .funct3      (funct3_in),
      .load_data_c (load_data)
   );

   // Next state, timeout counter, stall and next output-register values
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = dmem_req;
      we_d      = dmem_we;
      addr_d    = dmem_addr;
      wdata_d   = dmem_wdata;
      be_d      = dmem_be;
      wb_d      = wb_data_out;
      rd_d      = rd_out;
      rw_d      = 1'b0;
      mis_d     = 1'b0;
      berr_d    = 1'b0;
      stall_out = 1'b0;

      if (state_q != ST_IDLE && !timeout) begin
         cnt_d = cnt_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (!mem_op) begin
               wb_d = alu_result_in;
               rd_d = rd_in;
               rw_d = reg_write_in;
            end else if (misaligned) begin
               mis_d = 1'b1;
               wb_d  = '0;
               rd_d  = rd_in;
            end else begin
               stall_out = 1'b1;
               req_d     = 1'b1;
               we_d      = mem_write_in;
               addr_d    = {alu_result_in[31:2], 2'b00};
               wdata_d   = store_wdata(funct3_in[1:0], rs2_data_in);
               be_d      = mem_write_in ? store_be(funct3_in[1:0], alu_result_in[1:0]) : BE_WORD;
               cnt_d     = '0;
               state_d   = ST_REQ;
            end
         end
         ST_REQ: begin
            if (timeout) begin
               berr_d  = 1'b1;
               req_d   = 1'b0;
               wb_d    = '0;
               rd_d    = rd_in;
               state_d = ST_IDLE;
            end else begin
               stall_out = 1'b1;
               if (dmem_gnt) begin
                  req_d   = 1'b0;
                  state_d = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            if (dmem_rvalid) begin
               wb_d    = mem_read_in ? load_data : '0;
               rd_d    = rd_in;
               rw_d    = mem_read_in & reg_write_in;
               state_d = ST_IDLE;
            end else if (timeout) begin
               berr_d  = 1'b1;
               wb_d    = '0;
               rd_d    = rd_in;
               state_d = ST_IDLE;
            end else begin
               stall_out = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // FSM state and timeout counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Request and writeback output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         dmem_req         <= 1'b0;
         dmem_we          <= 1'b0;
         dmem_addr        <= '0;
         dmem_wdata       <= '0;
         dmem_be          <= '0;
         wb_data_out      <= '0;
         rd_out           <= '0;
         reg_write_out    <= 1'b0;
         misalign_err_out <= 1'b0;
         bus_err_out      <= 1'b0;
      end else begin
         dmem_req         <= req_d;
         dmem_we          <= we_d;
         dmem_addr        <= addr_d;
         dmem_wdata       <= wdata_d;
         dmem_be          <= be_d;
         wb_data_out      <= wb_d;
         rd_out           <= rd_d;
         reg_write_out    <= rw_d;
         misalign_err_out <= mis_d;
         bus_err_out      <= berr_d;
      end
   end

endmodule
